// File: rtl/barrel_pkg.sv
// barrel_pkg
// Shared definitions for the barrel core memory path:
//   - resp_e          : response tracking states of mem_arbiter
//   - STARVE_LIMIT_DEFAULT : default fetch starvation guard
//   - BWE_*           : common store byte-enable patterns
package barrel_pkg;

    // Which requester (if any) owns the RAM response arriving next cycle.
    // The *_OOR states mark accesses that never touched the RAM and must
    // return zero data.
    typedef enum logic [2:0] {
        RESP_NONE      = 3'd0,
        RESP_FETCH     = 3'd1,
        RESP_LOAD      = 3'd2,
        RESP_LOAD_OOR  = 3'd3,
        RESP_FETCH_OOR = 3'd4
    } resp_e;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    localparam logic [3:0] BWE_WORD    = 4'b1111;
    localparam logic [3:0] BWE_HALF_LO = 4'b0011;
    localparam logic [3:0] BWE_HALF_HI = 4'b1100;

endpackage : barrel_pkg

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port ram32 between the instruction-fetch port and the
// load/store port of the barrel core. One access per cycle, data first,
// with a starvation guard that hands the RAM to fetch after STARVE_LIMIT
// consecutive data grants while fetch waits. Read responses (1-cycle RAM
// latency) are steered back to the port that issued them.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt       fetch request / word address / accept
//   i_rvalid, i_rdata           fetch response (data gated by valid)
//   d_req/d_we/d_addr/d_wdata/d_bwe -> d_gnt   data request / accept
//   d_rvalid, d_rdata, d_err    load response, out-of-range error pulse
//   ram_addr/ram_din/ram_bwe/ram_ren -> ram32, ram_dout <- ram32
module mem_arbiter
    import barrel_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic [31:2]           i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:2]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_bwe,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:2] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_bwe,
    output logic                  ram_ren,
    input  logic [31:0]           ram_dout
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    resp_e            resp_reg, resp_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic             d_err_reg, d_err_next;

    logic i_oor, d_oor, fetch_turn;

    assign i_oor      = |i_addr[31:ADDR_WIDTH];
    assign d_oor      = |d_addr[31:ADDR_WIDTH];
    assign fetch_turn = (starve_cnt_reg == CNT_MAX);

    // Grants are forced low during reset so nothing reaches the RAM while
    // the response tracker is being cleared.
    assign i_gnt = resetn & i_req & (~d_req | fetch_turn);
    assign d_gnt = resetn & d_req & ~(i_req & fetch_turn);

    // RAM drive: out-of-range accesses are granted but leave the RAM idle.
    always_comb begin
        ram_ren  = 1'b0;
        ram_bwe  = 4'b0000;
        ram_addr = '0;
        ram_din  = 32'h0;
        if (i_gnt && !i_oor) begin
            ram_ren  = 1'b1;
            ram_addr = i_addr[ADDR_WIDTH-1:2];
        end else if (d_gnt && !d_oor) begin
            ram_addr = d_addr[ADDR_WIDTH-1:2];
            if (d_we) begin
                ram_bwe = d_bwe;
                ram_din = d_wdata;
            end else begin
                ram_ren = 1'b1;
            end
        end
    end

    always_comb begin
        resp_next = RESP_NONE;
        if (i_gnt)
            resp_next = i_oor ? RESP_FETCH_OOR : RESP_FETCH;
        else if (d_gnt && !d_we)
            resp_next = d_oor ? RESP_LOAD_OOR : RESP_LOAD;

        d_err_next = d_gnt & d_oor;

        // Counts data grants that happened while fetch was waiting.
        starve_cnt_next = starve_cnt_reg;
        if (i_gnt || !i_req)
            starve_cnt_next = '0;
        else if (d_gnt && starve_cnt_reg != CNT_MAX)
            starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_reg       <= RESP_NONE;
            starve_cnt_reg <= '0;
            d_err_reg      <= 1'b0;
        end else begin
            resp_reg       <= resp_next;
            starve_cnt_reg <= starve_cnt_next;
            d_err_reg      <= d_err_next;
        end
    end

    assign i_rvalid = (resp_reg == RESP_FETCH) || (resp_reg == RESP_FETCH_OOR);
    assign d_rvalid = (resp_reg == RESP_LOAD)  || (resp_reg == RESP_LOAD_OOR);
    assign i_rdata  = (resp_reg == RESP_FETCH) ? ram_dout : 32'h0;
    assign d_rdata  = (resp_reg == RESP_LOAD)  ? ram_dout : 32'h0;
    assign d_err    = d_err_reg;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural ram32 beside it.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge (registered responses) or 1 ns after driving (combinational grants).
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:2] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:2] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_bwe;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [11:2] ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_bwe;
    logic        ram_ren;
    logic [31:0] ram_dout;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_WIDTH(12), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_bwe(d_bwe), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_bwe(ram_bwe),
        .ram_ren(ram_ren), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram32: byte-enabled write, registered read.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_ren) ram_dout <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_bwe[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".i_gnt"},    {31'h0, i_gnt},    32'h0);
        check_eq({tag, ".d_gnt"},    {31'h0, d_gnt},    32'h0);
        check_eq({tag, ".i_rvalid"}, {31'h0, i_rvalid}, 32'h0);
        check_eq({tag, ".d_rvalid"}, {31'h0, d_rvalid}, 32'h0);
        check_eq({tag, ".d_err"},    {31'h0, d_err},    32'h0);
        check_eq({tag, ".i_rdata"},  i_rdata,           32'h0);
        check_eq({tag, ".d_rdata"},  d_rdata,           32'h0);
        check_eq({tag, ".ram_ren"},  {31'h0, ram_ren},  32'h0);
        check_eq({tag, ".ram_bwe"},  {28'h0, ram_bwe},  32'h0);
        check_eq({tag, ".ram_addr"}, {22'h0, ram_addr}, 32'h0);
        check_eq({tag, ".ram_din"},  ram_din,           32'h0);
    endtask

    function automatic logic [29:0] wa(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_bwe = '0;
    endtask

    logic [9:0] pat_i;
    logic       prev_i;

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        mem[0] = 32'hA0A0A0A0;   // byte 0x00
        mem[1] = 32'hB1B1B1B1;   // byte 0x04
        mem[2] = 32'hC2C2C2C2;   // byte 0x08
        mem[4] = 32'hDEADBEEF;   // byte 0x10
        mem[8] = 32'h11223344;   // byte 0x20

        // Reset with both ports requesting: everything must stay 0.
        resetn = 1'b0;
        idle_inputs();
        i_req = 1'b1; d_req = 1'b1; d_addr = wa(32'h4);
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Fetch only, first cycle after reset release.
        resetn = 1'b1;
        idle_inputs();
        i_req = 1'b1; i_addr = wa(32'h10);
        #1;
        check_eq("fetch.i_gnt",    {31'h0, i_gnt},    32'h1);
        check_eq("fetch.d_gnt",    {31'h0, d_gnt},    32'h0);
        check_eq("fetch.ram_ren",  {31'h0, ram_ren},  32'h1);
        check_eq("fetch.ram_addr", {22'h0, ram_addr}, 32'h4);
        @(negedge clk);
        check_eq("fetch.i_rvalid", {31'h0, i_rvalid}, 32'h1);
        check_eq("fetch.i_rdata",  i_rdata,           32'hDEADBEEF);
        check_eq("fetch.d_rvalid", {31'h0, d_rvalid}, 32'h0);

        // Store one byte lane, then load the same word the next cycle.
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_addr = wa(32'h20);
        d_bwe = 4'b0100; d_wdata = 32'h00AB0000;
        #1;
        check_eq("store.d_gnt",    {31'h0, d_gnt},    32'h1);
        check_eq("store.ram_ren",  {31'h0, ram_ren},  32'h0);
        check_eq("store.ram_bwe",  {28'h0, ram_bwe},  32'h4);
        check_eq("store.ram_din",  ram_din,           32'h00AB0000);
        check_eq("store.ram_addr", {22'h0, ram_addr}, 32'h8);
        @(negedge clk);
        check_eq("store.no_rvalid", {31'h0, d_rvalid}, 32'h0);
        check_eq("store.no_err",    {31'h0, d_err},    32'h0);
        d_we = 1'b0; d_bwe = 4'b0000; d_wdata = 32'h0;
        #1;
        check_eq("load.d_gnt",   {31'h0, d_gnt},   32'h1);
        check_eq("load.ram_ren", {31'h0, ram_ren}, 32'h1);
        check_eq("load.ram_bwe", {28'h0, ram_bwe}, 32'h0);
        @(negedge clk);
        check_eq("load.d_rvalid", {31'h0, d_rvalid}, 32'h1);
        check_eq("load.d_rdata",  d_rdata,           32'h11AB3344);
        check_eq("load.i_rvalid", {31'h0, i_rvalid}, 32'h0);
        check_eq("load.i_rdata",  i_rdata,           32'h0);
        idle_inputs();

        // Contention: expected grants D,D,D,D,I,D,D,D,D,I (bit k = fetch).
        pat_i  = 10'b10_0001_0000;
        prev_i = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check_eq($sformatf("cont%0d.i_rvalid", k), {31'h0, i_rvalid}, {31'h0, prev_i});
                check_eq($sformatf("cont%0d.d_rvalid", k), {31'h0, d_rvalid}, {31'h0, ~prev_i});
                if (prev_i)
                    check_eq($sformatf("cont%0d.i_rdata", k), i_rdata, 32'hA0A0A0A0);
                else
                    check_eq($sformatf("cont%0d.d_rdata", k), d_rdata, 32'hB1B1B1B1);
            end
            if (k == 0) begin
                i_req = 1'b1; i_addr = wa(32'h0);
                d_req = 1'b1; d_we = 1'b0; d_addr = wa(32'h4);
            end
            if (k == 10) idle_inputs();
            #1;
            if (k < 10) begin
                check_eq($sformatf("cont%0d.i_gnt", k), {31'h0, i_gnt}, {31'h0, pat_i[k]});
                check_eq($sformatf("cont%0d.d_gnt", k), {31'h0, d_gnt}, {31'h0, ~pat_i[k]});
                prev_i = pat_i[k];
            end
        end

        // Out-of-range load, store and fetch.
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2000_0008;
        #1;
        check_eq("oorld.d_gnt",   {31'h0, d_gnt},   32'h1);
        check_eq("oorld.ram_ren", {31'h0, ram_ren}, 32'h0);
        @(negedge clk);
        check_eq("oorld.d_err",    {31'h0, d_err},    32'h1);
        check_eq("oorld.d_rvalid", {31'h0, d_rvalid}, 32'h1);
        check_eq("oorld.d_rdata",  d_rdata,           32'h0);
        d_we = 1'b1; d_addr = 30'h0000_0400; d_bwe = 4'b1111; d_wdata = 32'h12345678;
        #1;
        check_eq("oorst.d_gnt",   {31'h0, d_gnt},   32'h1);
        check_eq("oorst.ram_bwe", {28'h0, ram_bwe}, 32'h0);
        @(negedge clk);
        check_eq("oorst.d_err",    {31'h0, d_err},    32'h1);
        check_eq("oorst.d_rvalid", {31'h0, d_rvalid}, 32'h0);
        idle_inputs();
        i_req = 1'b1; i_addr = 30'h1000_0000;
        #1;
        check_eq("oorif.i_gnt",   {31'h0, i_gnt},   32'h1);
        check_eq("oorif.ram_ren", {31'h0, ram_ren}, 32'h0);
        @(negedge clk);
        check_eq("oorif.i_rvalid", {31'h0, i_rvalid}, 32'h1);
        check_eq("oorif.i_rdata",  i_rdata,           32'h0);
        check_eq("oorif.d_err",    {31'h0, d_err},    32'h0);

        // Back-to-back alternating: I@0x0, D@0x4, I@0x8.
        i_addr = wa(32'h0);
        #1;
        check_eq("alt0.i_gnt", {31'h0, i_gnt}, 32'h1);
        @(negedge clk);
        check_eq("alt1.i_rvalid", {31'h0, i_rvalid}, 32'h1);
        check_eq("alt1.i_rdata",  i_rdata,           32'hA0A0A0A0);
        idle_inputs();
        d_req = 1'b1; d_addr = wa(32'h4);
        #1;
        check_eq("alt1.d_gnt", {31'h0, d_gnt}, 32'h1);
        @(negedge clk);
        check_eq("alt2.d_rvalid", {31'h0, d_rvalid}, 32'h1);
        check_eq("alt2.d_rdata",  d_rdata,           32'hB1B1B1B1);
        check_eq("alt2.i_rvalid", {31'h0, i_rvalid}, 32'h0);
        idle_inputs();
        i_req = 1'b1; i_addr = wa(32'h8);
        #1;
        check_eq("alt2.i_gnt", {31'h0, i_gnt}, 32'h1);
        @(negedge clk);
        check_eq("alt3.i_rvalid", {31'h0, i_rvalid}, 32'h1);
        check_eq("alt3.i_rdata",  i_rdata,           32'hC2C2C2C2);
        check_eq("alt3.d_rvalid", {31'h0, d_rvalid}, 32'h0);
        idle_inputs();

        // Reset asserted between a load grant and its sampling edge.
        d_req = 1'b1; d_addr = wa(32'h4);
        #1;
        check_eq("rstrd.d_gnt", {31'h0, d_gnt}, 32'h1);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("rstrd.gnt_in_rst", {31'h0, d_gnt}, 32'h0);
        idle_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("rstrd");
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rstrd.post_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        check_eq("rstrd.post_i_rvalid", {31'h0, i_rvalid}, 32'h0);
        @(negedge clk);
        check_eq("rstrd.post2_d_rvalid", {31'h0, d_rvalid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one `ram32` instance between the barrel core's instruction-fetch port and its load/store port. It is the step toward a unified memory. It takes at most one access per cycle, with data priority and a starvation guard for fetch. It tracks the 1-cycle RAM read latency and routes each read response back to the requester that issued it. It sits between `barrel` and `ram32`.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: byte-address width of the RAM; word address is `[ADDR_WIDTH-1:2]`.
- `STARVE_LIMIT`, 4: consecutive data grants allowed while a fetch waits; the next arbitration then goes to fetch.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset. Asynchronous, active-low.
- `i_req` in 1: fetch request. Held with `i_addr` stable until granted.
- `i_addr` in [31:2]: fetch word address.
- `i_gnt` out 1: fetch accepted this cycle.
- `i_rvalid` out 1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata` out 32: fetched word.
- `d_req` in 1: data request. Held with address and payload stable until granted.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in [31:2]: data word address.
- `d_wdata` in 32: store data, already lane-replicated.
- `d_bwe` in 4: store byte enables. Ignored for loads.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: one-cycle pulse; load data is valid.
- `d_rdata` out 32: load word.
- `d_err` out 1: one-cycle pulse, one cycle after the grant, for an out-of-range data access.
- `ram_addr` out [ADDR_WIDTH-1:2]: to `ram32`.
- `ram_din` out 32: to `ram32`.
- `ram_bwe` out 4: to `ram32`.
- `ram_ren` out 1: to `ram32`.
- `ram_dout` in 32: from `ram32`.

## Operation
- Grants are combinational from current requests and registered state. At most one of `i_gnt`/`d_gnt` is high per cycle. Both are 0 while `resetn` is low.
- Priority when both ports request:
  - Data wins by default.
  - Fetch wins if `starve_cnt == STARVE_LIMIT`.
- `starve_cnt` update, per cycle:
  - Increments (saturating at `STARVE_LIMIT`) on a data grant while `i_req` is high.
  - Clears on a fetch grant or when `i_req` is low.
- Granted fetch drives the RAM with `ram_ren`=1, `ram_bwe`=0, `ram_addr`=`i_addr[ADDR_WIDTH-1:2]`.
- Granted load drives the RAM with `ram_ren`=1, `ram_bwe`=0, `ram_addr` from `d_addr`.
- Granted store drives the RAM with `ram_ren`=0, `ram_bwe`=`d_bwe`, `ram_din`=`d_wdata`. A store produces no `d_rvalid`.
- Out-of-range access: any bit of `d_addr[31:ADDR_WIDTH]` or `i_addr[31:ADDR_WIDTH]` is set.
  - The access is still granted, but the RAM is not driven (`ram_ren`=0, `ram_bwe`=0).
  - Data port: `d_err` pulses; a load also pulses `d_rvalid` with `d_rdata`=0.
  - Fetch port: `i_rvalid` pulses with `i_rdata`=0.
- Response tracking uses a registered `resp` field: NONE, FETCH, LOAD, LOAD_OOR or FETCH_OOR, written every cycle from the current grant.
- `i_rdata`/`d_rdata` carry `ram_dout`, or 0 in the OOR states. Each is gated with its own rvalid, so it reads 0 when not valid.
- When no port is granted: `ram_ren`=0, `ram_bwe`=0, `ram_addr`=0, `ram_din`=0. Idle outputs are deterministic, not x.

## Timing
- Grant in cycle N. RAM samples at the N→N+1 edge. rvalid and rdata are valid throughout cycle N+1.
- Read latency is 1 cycle after grant. Throughput is one access per cycle, back-to-back, with alternating ports allowed.
- Store in cycle N followed by a load to the same address in N+1: the load returns the new data.
- A requester may drop `req` the cycle after its grant. Keeping `req` high is a new request.
- Asynchronous reset mid-operation:
  - `resp` returns to NONE and `starve_cnt` to 0.
  - Any pending response is dropped: no rvalid after reset release.
- Reset values: `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `d_err` = 0; `i_rdata`, `d_rdata` = 0; `ram_ren`, `ram_bwe`, `ram_addr`, `ram_din` = 0.
- First grant is possible in the first cycle after `resetn` rises.

## Structure
- Shared package `barrel_pkg`:
  - `resp` state encodings (NONE/FETCH/LOAD/LOAD_OOR/FETCH_OOR).
  - Default `STARVE_LIMIT`.
  - Byte-enable constants `BWE_WORD`=4'b1111, `BWE_HALF_LO`=4'b0011, `BWE_HALF_HI`=4'b1100.
- Single module, no sub-module. `ram32` is instantiated beside it by the parent.

## Test plan
- Fetch only: `i_req`, `i_addr`=0x10 with mem[0x10]=0xDEADBEEF → `i_gnt` in cycle 0; `i_rvalid`=1, `i_rdata`=0xDEADBEEF in cycle 1.
- Store then load: store `d_addr`=0x20, `d_bwe`=4'b0100, `d_wdata`=0x00AB0000 over old word 0x11223344; load 0x20 next cycle → `d_rdata`=0x11AB3344 one cycle after the load grant; no `d_rvalid` for the store.
- Contention: `i_req` and `d_req` held high, `STARVE_LIMIT`=4 → grant sequence is D,D,D,D,I,D,D,D,D,I…
- Out-of-range: load with `d_addr[31:12]`≠0 → `ram_ren`=0; next cycle `d_err`=1, `d_rvalid`=1, `d_rdata`=0.
- Reset mid-read: load granted, `resetn` asserted low before the next edge → no `d_rvalid` after release; all outputs 0 during reset.
- Back-to-back alternating: I@0x0, D-load@0x4, I@0x8 on consecutive cycles → three responses on consecutive cycles, each on the correct port with the correct data.
